fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 2-stage (F/E) pipeline. Holds the PC, drives the instruction-memory address, and decodes source-register fields for the hazard unit. Registers the fetched instruction into the F/E pipeline register consumed by execute. Honours the hazard unit's fetch-stall and control-flush requests, redirects to taken-branch targets, and keeps saturating fetch/bubble counters for performance checks.

## Interface
- ADDR_W, 8, instruction-memory word-address width; PC width.
- INSTR_W, 16, instruction width; fields: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stallF  in  1  hazard unit: hold PC, insert bubble into E.
- stallC  in  1  hazard unit: control flush; discard instruction in F, insert bubble into E.
- isBranchTakenE  in  1  execute: branch in E resolved taken.
- branch_target_e  in  ADDR_W  execute: target of taken branch.
- imem_addr  out  ADDR_W  equals PC (pc_f), combinational.
- imem_en  out  1  fetch enable; 0 in BOOT, 1 otherwise.
- imem_rdata  in  INSTR_W  combinational-read instruction at imem_addr, valid same cycle.
- rs1F  out  4  imem_rdata[7:4]; forced 0 when imem_en=0.
- rs2F  out  4  imem_rdata[3:0]; forced 0 when imem_en=0.
- instr_e  out  INSTR_W  F/E register: instruction.
- pc_e  out  ADDR_W  F/E register: PC of instr_e.
- valid_e  out  1  F/E register: instr_e is real (0 = bubble).
- fetch_cnt  out  CNT_W  instructions committed into F/E, saturating.
- bubble_cnt  out  CNT_W  bubbles inserted into F/E after BOOT, saturating.

## Operation
- FSM states: BOOT, RUN, FLUSH. Reset -> BOOT.
- BOOT: one cycle; imem_en=0, no PC change, valid_e<=0, counters unchanged. -> RUN.
- RUN, priority highest first:
  - isBranchTakenE=1: pc_f<=branch_target_e; valid_e<=0; bubble_cnt++; -> FLUSH.
  - stallC=1: pc_f holds; valid_e<=0; bubble_cnt++; stay RUN.
  - stallF=1: pc_f holds; valid_e<=0; instr_e/pc_e hold; bubble_cnt++.
  - else: instr_e<=imem_rdata, pc_e<=pc_f, valid_e<=1, pc_f<=pc_f+1, fetch_cnt++.
- FLUSH: one cycle covering the hazard unit's stallC pulse following a branch. Instruction at target is fetched but not committed: valid_e<=0, pc_f holds, bubble_cnt++. Any isBranchTakenE in FLUSH is ignored (the E slot holds a bubble). -> RUN.
- PC increment is modulo 2^ADDR_W: pc_f=2^ADDR_W-1 wraps to 0 with no flag.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Whenever valid_e=0, instr_e/pc_e hold their last value. Execute must gate on valid_e.

## Timing
- Reset values: pc_f=RESET_PC, imem_addr=RESET_PC, imem_en=0, instr_e=0, pc_e=0, valid_e=0, fetch_cnt=0, bubble_cnt=0, state=BOOT.
- Reset asserted mid-operation clears everything asynchronously. First fetch occurs the cycle after BOOT.
- Fetch latency: instruction at PC n appears on instr_e one cycle after imem_addr=n, absent stalls.
- Branch penalty: exactly 2 bubbles (RUN->FLUSH edge, FLUSH->RUN edge). First target instruction is valid on the 3rd edge after isBranchTakenE is sampled.
- stallF/stallC are sampled on the rising edge. Each cycle held adds one bubble.
- rs1F/rs2F are combinational from imem_rdata. They stay valid during stall, since the PC holds.

## Structure
- Shared package pipe_pkg: ADDR_W/INSTR_W defaults, field position constants (OPC_MSB..RS2_LSB), fetch_state_t enum {BOOT, RUN, FLUSH}.
- One sub-module: sat_counter (parameter CNT_W; inc, clk, reset, count), instantiated twice.
- Everything else is in fetch_stage: PC register, FSM, F/E register, field decode.

## Test plan
- Reset then run with no hazards, imem[i]=i*0x0111 -> cycle 0 BOOT valid_e=0; then instr_e=0x0000,0x0111,0x0222 on successive edges; pc_e=0,1,2; fetch_cnt=3, bubble_cnt=0.
- stallF high for 2 cycles at pc_f=5 -> pc_f stays 5, two bubbles (valid_e=0), then instr_e=imem[5], pc_e=5; bubble_cnt=2.
- isBranchTakenE=1, branch_target_e=0x40 at pc_f=9 -> next imem_addr=0x40, 2 bubbles, then pc_e=0x40 valid_e=1.
- Simultaneous isBranchTakenE=1 and stallF=1 -> branch wins, pc_f=target, FSM=FLUSH; also branch asserted during FLUSH -> ignored.
- ADDR_W=8, start at pc_f=0xFF -> pc_e=0xFF then 0x00; counters preset near max -> saturate at 0xFFFF.
- Assert reset mid-stream (valid_e=1, pc_f=0x23) -> all outputs return to reset values immediately, before next edge; BOOT cycle repeats.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the 2-stage (F/E) pipeline: default
//                widths, instruction field positions and the fetch FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Default widths
    localparam int unsigned c_ADDR_W  = 8;
    localparam int unsigned c_INSTR_W = 16;

    // Instruction field positions: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
    localparam int unsigned c_OPC_MSB = 15;
    localparam int unsigned c_OPC_LSB = 12;
    localparam int unsigned c_RD_MSB  = 11;
    localparam int unsigned c_RD_LSB  = 8;
    localparam int unsigned c_RS1_MSB = 7;
    localparam int unsigned c_RS1_LSB = 4;
    localparam int unsigned c_RS2_MSB = 3;
    localparam int unsigned c_RS2_LSB = 0;

    // Fetch FSM states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value instead of
//                wrapping.
//  Ports       : clk   - clock
//                reset - asynchronous active-high reset, clears count
//                inc   - increment request for this cycle
//                count - current count value
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage of the F/E pipeline. Holds the PC,
//                drives the instruction memory, decodes rs1/rs2 for the hazard
//                unit and loads the F/E pipeline register. Handles fetch
//                stalls, control flushes and taken-branch redirects, and keeps
//                saturating fetch/bubble performance counters.
//  Ports       : clk, reset          - clock, async active-high reset
//                stallF, stallC      - hazard unit fetch stall / control flush
//                isBranchTakenE,
//                branch_target_e     - branch redirect from execute
//                imem_addr, imem_en,
//                imem_rdata          - instruction memory interface
//                rs1F, rs2F          - source register fields of fetched instr
//                instr_e, pc_e,
//                valid_e             - F/E pipeline register
//                fetch_cnt,
//                bubble_cnt          - saturating performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int unsigned              ADDR_W   = c_ADDR_W,
    parameter int unsigned              INSTR_W  = c_INSTR_W,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0,
    parameter int unsigned              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallF,
    input  logic               stallC,
    input  logic               isBranchTakenE,
    input  logic [ADDR_W-1:0]  branch_target_e,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         rs1F,
    output logic [3:0]         rs2F,
    output logic [INSTR_W-1:0] instr_e,
    output logic [ADDR_W-1:0]  pc_e,
    output logic               valid_e,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [ADDR_W-1:0]  r_pc_f;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [INSTR_W-1:0] r_instr_e;
    logic [ADDR_W-1:0]  r_pc_e;
    logic               r_valid_e;
    logic               w_commit;       // load F/E register with the fetched instruction
    logic               w_bubble;       // a bubble enters E this edge (not counted in BOOT)
    logic               w_fetch_en;

    // ------------------------------------------------------------------------
    // State and PC registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc_f  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc_f  <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, next-PC and F/E load control. In RUN a taken branch beats a
    // control flush, which beats a fetch stall. FLUSH absorbs the cycle in
    // which the wrong-path slot is squashed; a branch seen there comes from a
    // bubble in E and is ignored.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc_f;
        w_commit     = 1'b0;
        w_bubble     = 1'b0;
        w_fetch_en   = 1'b1;

        case (r_state)
            BOOT: begin
                w_fetch_en   = 1'b0;
                w_state_next = RUN;
            end
            RUN: begin
                if (isBranchTakenE) begin
                    w_pc_next    = branch_target_e;
                    w_bubble     = 1'b1;
                    w_state_next = FLUSH;
                end else if (stallC || stallF) begin
                    w_bubble     = 1'b1;
                end else begin
                    w_commit     = 1'b1;
                    w_pc_next    = r_pc_f + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                end
            end
            FLUSH: begin
                w_bubble     = 1'b1;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // F/E pipeline register. instr_e/pc_e only move on a commit so that they
    // keep their last value while valid_e is low.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_e <= '0;
            r_pc_e    <= '0;
            r_valid_e <= 1'b0;
        end else begin
            r_valid_e <= w_commit;
            if (w_commit) begin
                r_instr_e <= imem_rdata;
                r_pc_e    <= r_pc_f;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_commit),
        .count (fetch_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubble),
        .count (bubble_cnt)
    );

    // ------------------------------------------------------------------------
    // Outputs and field decode
    // ------------------------------------------------------------------------
    assign imem_addr = r_pc_f;
    assign imem_en   = w_fetch_en;
    assign rs1F      = w_fetch_en ? imem_rdata[c_RS1_MSB:c_RS1_LSB] : 4'd0;
    assign rs2F      = w_fetch_en ? imem_rdata[c_RS2_MSB:c_RS2_LSB] : 4'd0;
    assign instr_e   = r_instr_e;
    assign pc_e      = r_pc_e;
    assign valid_e   = r_valid_e;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A behavioural model of
//                the fetch rules predicts every output; directed scenarios are
//                followed by randomized hazards, branches and resets. A second
//                instance with 3-bit counters exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF, stallC, isBranchTakenE;
    logic [7:0]  branch_target_e;

    logic [7:0]  imem_addr, pc_e;
    logic        imem_en, valid_e;
    logic [15:0] imem_rdata, instr_e;
    logic [3:0]  rs1F, rs2F;
    logic [15:0] fetch_cnt, bubble_cnt;

    logic [7:0]  imem_addr_s, pc_e_s;
    logic        imem_en_s, valid_e_s;
    logic [15:0] imem_rdata_s, instr_e_s;
    logic [3:0]  rs1F_s, rs2F_s;
    logic [2:0]  fetch_cnt_s, bubble_cnt_s;

    logic [15:0] mem [256];

    assign imem_rdata   = mem[imem_addr];
    assign imem_rdata_s = mem[imem_addr_s];

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .stallF          (stallF),
        .stallC          (stallC),
        .isBranchTakenE  (isBranchTakenE),
        .branch_target_e (branch_target_e),
        .imem_addr       (imem_addr),
        .imem_en         (imem_en),
        .imem_rdata      (imem_rdata),
        .rs1F            (rs1F),
        .rs2F            (rs2F),
        .instr_e         (instr_e),
        .pc_e            (pc_e),
        .valid_e         (valid_e),
        .fetch_cnt       (fetch_cnt),
        .bubble_cnt      (bubble_cnt)
    );

    fetch_stage #(
        .CNT_W (3)
    ) u_dut_sat (
        .clk             (clk),
        .reset           (reset),
        .stallF          (stallF),
        .stallC          (stallC),
        .isBranchTakenE  (isBranchTakenE),
        .branch_target_e (branch_target_e),
        .imem_addr       (imem_addr_s),
        .imem_en         (imem_en_s),
        .imem_rdata      (imem_rdata_s),
        .rs1F            (rs1F_s),
        .rs2F            (rs2F_s),
        .instr_e         (instr_e_s),
        .pc_e            (pc_e_s),
        .valid_e         (valid_e_s),
        .fetch_cnt       (fetch_cnt_s),
        .bubble_cnt      (bubble_cnt_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_pc, m_pce, m_fetch, m_bubble;
    logic [15:0] m_instr;
    bit          m_valid, m_boot, m_flush;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pce = 0; m_instr = '0; m_valid = 0;
        m_fetch = 0; m_bubble = 0; m_boot = 1; m_flush = 0;
    endtask

    // One rising edge worth of fetch-stage behaviour.
    task automatic model_step();
        if (m_boot) begin
            m_boot  = 0;
            m_valid = 0;
        end else if (m_flush) begin
            m_flush = 0;
            m_valid = 0;
            m_bubble++;
        end else if (isBranchTakenE) begin
            m_pc    = int'(branch_target_e);
            m_valid = 0;
            m_flush = 1;
            m_bubble++;
        end else if (stallC || stallF) begin
            m_valid = 0;
            m_bubble++;
        end else begin
            m_instr = mem[m_pc];
            m_pce   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 256;
            m_fetch++;
        end
    endtask

    task automatic check_outputs();
        logic [15:0] word;
        word = mem[m_pc];
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_en", imem_en, !m_boot);
        chk("rs1F", rs1F, m_boot ? 0 : word[7:4]);
        chk("rs2F", rs2F, m_boot ? 0 : word[3:0]);
        chk("valid_e", valid_e, m_valid);
        chk("instr_e", instr_e, m_instr);
        chk("pc_e", pc_e, m_pce);
        chk("fetch_cnt", fetch_cnt, sat(m_fetch, 65535));
        chk("bubble_cnt", bubble_cnt, sat(m_bubble, 65535));
        chk("sat_fetch_cnt", fetch_cnt_s, sat(m_fetch, 7));
        chk("sat_bubble_cnt", bubble_cnt_s, sat(m_bubble, 7));
        chk("sat_imem_addr", imem_addr_s, m_pc);
    endtask

    // Check mid-cycle, then step the model on the edge; returns 1 ns after it.
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Reset asserted mid-cycle must clear outputs before any clock edge.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic set_in(input bit f, input bit c, input bit b, input int t);
        stallF = f; stallC = c; isBranchTakenE = b; branch_target_e = 8'(t);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0111);
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        reset = 1'b0;

        // No hazards: BOOT then three fetches
        repeat (4) run_cycle();
        chk("dir_instr2", instr_e, 16'h0222);
        chk("dir_pc_e2", pc_e, 2);
        chk("dir_fetch3", fetch_cnt, 3);
        chk("dir_bubble0", bubble_cnt, 0);

        // Fetch stall for two cycles at pc 5
        repeat (2) run_cycle();
        chk("dir_pc5", imem_addr, 5);
        set_in(1, 0, 0, 0);
        repeat (2) run_cycle();
        set_in(0, 0, 0, 0);
        chk("dir_stall_valid", valid_e, 0);
        chk("dir_stall_pc", imem_addr, 5);
        chk("dir_stall_bub", bubble_cnt, 2);
        run_cycle();
        chk("dir_after_stall_instr", instr_e, 16'h0555);
        chk("dir_after_stall_pc", pc_e, 5);

        // Taken branch at pc 9 to 0x40
        repeat (3) run_cycle();
        chk("dir_pc9", imem_addr, 9);
        set_in(0, 0, 1, 'h40);
        run_cycle();
        set_in(0, 0, 0, 0);
        chk("dir_br_addr", imem_addr, 8'h40);
        run_cycle();
        chk("dir_br_bubble", valid_e, 0);
        chk("dir_br_bubcnt", bubble_cnt, 4);
        run_cycle();
        chk("dir_br_pc_e", pc_e, 8'h40);
        chk("dir_br_valid", valid_e, 1);

        // Branch together with stallF, then a branch during FLUSH
        set_in(1, 0, 1, 'h80);
        run_cycle();
        chk("dir_brst_addr", imem_addr, 8'h80);
        set_in(0, 0, 1, 'h10);
        run_cycle();
        set_in(0, 0, 0, 0);
        chk("dir_flush_ignore", imem_addr, 8'h80);
        run_cycle();
        chk("dir_brst_pc_e", pc_e, 8'h80);

        // PC wrap at 0xFF
        set_in(0, 0, 1, 'hFF);
        run_cycle();
        set_in(0, 0, 0, 0);
        repeat (2) run_cycle();
        chk("dir_wrap_ff", pc_e, 8'hFF);
        chk("dir_wrap_addr", imem_addr, 0);
        run_cycle();
        chk("dir_wrap_00", pc_e, 0);

        // Control flush
        set_in(0, 1, 0, 0);
        run_cycle();
        set_in(0, 0, 0, 0);
        chk("dir_stallc_valid", valid_e, 0);
        run_cycle();

        // Reset mid-stream while valid
        chk("dir_pre_reset_valid", valid_e, 1);
        mid_reset();
        chk("dir_reset_valid", valid_e, 0);
        chk("dir_reset_en", imem_en, 0);
        repeat (2) run_cycle();

        // Randomized hazards, branches and resets
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 99) == 0) mid_reset();
            run_cycle();
        end
        set_in(0, 0, 0, 0);
        repeat (3) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_stage
`default_nettype wire
